zbuff_mem_port: RTL and testbench
=================================

Name: zbuff_mem_port

Overview:
- Memory-side responder for the hline z-buffer FSM.
- Accepts burst read/write requests (rd_req/wr_req, addr, len) from the FSM and runs them as single-word transfers on a pipelined Avalon-style master port.
- Read data is pushed into the z read FIFO; write data and halfword enables are popped from the zbuffout and byte-enable FIFOs.
- Signals completion to the FSM with a one-cycle axi_done pulse.

Parameters:
- MAX_OUT, 4: maximum outstanding reads on the memory bus.
- LEN_W, 9: width of the burst length field; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  one-cycle read request pulse, sampled only in IDLE
- wr_req  in  1  one-cycle write request pulse, sampled only in IDLE
- addr  in  32  start byte address; bits [1:0] ignored (forced 0)
- len  in  LEN_W  number of 32-bit words
- busy  out  1  high from the accepted request until the axi_done cycle, inclusive
- axi_done  out  1  one-cycle completion pulse
- zfifo_wdata  out  32  read data to the z read FIFO
- write_zfifo  out  1  push strobe
- zfifo_afull  in  1  high when fewer than MAX_OUT entries are free
- zout_data  in  32  show-ahead head of the zbuffout FIFO
- zout_empty  in  1
- read_zbuffout_fifo  out  1  pop strobe
- be_data  in  2  show-ahead head of the be FIFO; bit0 = low halfword, bit1 = high halfword
- be_empty  in  1
- read_be_fifo  out  1  pop strobe
- mem_addr  out  32
- mem_read  out  1
- mem_write  out  1
- mem_wdata  out  32
- mem_byteenable  out  4
- mem_waitrequest  in  1
- mem_readdata  in  32
- mem_readdatavalid  in  1

Behaviour:
- Reset values: all outputs 0. Reset clears state to IDLE and zeroes all counters.
- Any mem_readdatavalid arriving after reset with outstanding==0 is ignored.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - rd_req -> latch addr & ~3 and len; go to READ.
  - wr_req -> same latching; go to WRITE.
  - Both asserted together: read wins; wr_req is dropped.
  - len==0 -> go to DONE directly, with no bus activity.
- READ:
  - Issue condition: issued<len, outstanding<MAX_OUT, and !zfifo_afull.
  - When the issue condition holds, drive mem_read=1 with mem_addr = base + 4*issued.
  - mem_read/mem_addr stay stable while mem_waitrequest=1.
  - A read is accepted on a cycle with mem_read & !mem_waitrequest; then issued++ and outstanding++.
  - Each mem_readdatavalid: write_zfifo=1 and zfifo_wdata=mem_readdata in the same cycle (combinational passthrough), outstanding--, received++.
  - Accept and return in the same cycle leave outstanding unchanged.
  - received==len -> DONE.
- WRITE:
  - Drive mem_write=1 only when !zout_empty & !be_empty.
  - mem_wdata = zout_data; mem_addr = base + 4*written.
  - mem_byteenable = {be_data[1],be_data[1],be_data[0],be_data[0]}.
  - Accepted when mem_write & !mem_waitrequest. In that cycle pulse read_zbuffout_fifo and read_be_fifo together, and written++.
  - FIFO empty mid-burst: deassert mem_write and wait; this is not an error.
  - written==len -> DONE.
- DONE: axi_done=1 for exactly one cycle, busy=1, then IDLE. A new request is accepted the cycle after DONE.
- Requests while busy are ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Latency: rd_req to first mem_read is 1 cycle. The last accepted write or last readdatavalid is followed by axi_done 1 cycle later.

Optional Feature:
- Macro: ZBUFF_MEM_TIMEOUT_EN.
- When defined:
  - Adds output err_timeout (1) and parameter TIMEOUT (default 1024).
  - A 16-bit watchdog counts consecutive READ/WRITE cycles with no progress, where progress = an accepted transfer or a readdatavalid.
  - On reaching TIMEOUT, go to DONE. axi_done and err_timeout pulse together. Outstanding is cleared and later readdatavalids are ignored.
  - The watchdog resets on every progress event and in IDLE.
- When undefined: no watchdog and no err_timeout port; the block waits indefinitely.

Test Plan:
- Read: rd_req, addr=0x10000003, len=3, waitrequest=0, readdata returned 2 cycles after accept -> mem_read at 0x10000000/04/08 on consecutive cycles; 3 write_zfifo pulses with matching data; axi_done 1 cycle after the third; busy then low.
- Throttle: len=8, zfifo_afull forced high after 2 accepts -> no mem_read while afull; resume completes 8 words, never >4 outstanding.
- Write: wr_req, addr=0x00000100, len=2, zout data 0xAAAA5555/0x1234FFFF, be 2'b01/2'b11, waitrequest high 3 cycles on beat 0 -> byteenable 0011 then 1111 at 0x100/0x104; each FIFO popped once per accept; axi_done after beat 1.
- Boundaries: rd_req & wr_req same cycle -> read only. len=0 -> axi_done next cycle with no mem activity. zout_empty for 5 cycles mid-burst -> mem_write low, then resumes. addr=0xFFFFFFFC, len=2 -> second address 0x00000000.
- Reset mid-READ with 2 outstanding -> outputs 0 next cycle; two late readdatavalids produce no write_zfifo; a following rd_req behaves normally.
- With ZBUFF_MEM_TIMEOUT_EN, TIMEOUT=16: waitrequest held high -> axi_done and err_timeout pulse together 16 cycles after the request.

Source files
------------

// File: rtl/zbuff_mem_port.sv
// Burst read/write responder for the hline z-buffer FSM: 1 cycle request->bus, axi_done 1 cycle after last beat; stalls on afull/empty FIFOs.
// Optional no-progress watchdog with err_timeout output when ZBUFF_MEM_TIMEOUT_EN is defined.
module zbuff_mem_port #(
  parameter int MAX_OUT = 4,
  parameter int LEN_W   = 9
`ifdef ZBUFF_MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             axi_done,
`ifdef ZBUFF_MEM_TIMEOUT_EN
  output logic             err_timeout,
`endif
  output logic [31:0]      zfifo_wdata,
  output logic             write_zfifo,
  input  logic             zfifo_afull,
  input  logic [31:0]      zout_data,
  input  logic             zout_empty,
  output logic             read_zbuffout_fifo,
  input  logic [1:0]       be_data,
  input  logic             be_empty,
  output logic             read_be_fifo,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_byteenable,
  input  logic             mem_waitrequest,
  input  logic [31:0]      mem_readdata,
  input  logic             mem_readdatavalid
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      base;
  logic [LEN_W-1:0] len_q, issued, received, written;
  logic [OUT_W-1:0] outstanding;
  logic             rd_hold;
  logic             rd_issue_ok, rd_acc, rd_ret, wr_acc, rd_last, wr_last;
  logic             progress, timeout_hit;
  logic [31:0]      rd_addr, wr_addr;

  assign rd_issue_ok = (issued < len_q) && (outstanding < OUT_W'(MAX_OUT)) && !zfifo_afull;
  assign rd_acc      = mem_read && !mem_waitrequest;
  // Returns with nothing outstanding (e.g. after reset or timeout) are stale and dropped.
  assign rd_ret      = (state == READ) && mem_readdatavalid && (outstanding != '0);
  assign wr_acc      = mem_write && !mem_waitrequest;
  assign rd_last     = rd_ret && ((received + LEN_W'(1)) == len_q);
  assign wr_last     = wr_acc && ((written + LEN_W'(1)) == len_q);
  assign progress    = rd_acc || rd_ret || wr_acc;
  assign rd_addr     = base + 32'({issued, 2'b00});
  assign wr_addr     = base + 32'({written, 2'b00});

`ifdef ZBUFF_MEM_TIMEOUT_EN
  logic [15:0] wd;
  logic        err_q;

  // Fires after TIMEOUT-1 stalled cycles so axi_done lands TIMEOUT cycles after the request.
  assign timeout_hit = ((state == READ) || (state == WRITE)) && !progress &&
                       (wd == 16'(TIMEOUT - 2));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (((state == READ) || (state == WRITE)) && !progress)
        wd <= wd + 16'd1;
      else
        wd <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_req)      state_nxt = (len == '0) ? DONE : READ;
        else if (wr_req) state_nxt = (len == '0) ? DONE : WRITE;
      end
      READ:    if (rd_last || timeout_hit) state_nxt = DONE;
      WRITE:   if (wr_last || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy               = (state != IDLE);
    axi_done           = (state == DONE);
    // Once presented, a read is held until accepted even if afull rises meanwhile.
    mem_read           = (state == READ) && (rd_hold || rd_issue_ok);
    mem_write          = (state == WRITE) && !zout_empty && !be_empty;
    mem_addr           = 32'd0;
    if (mem_read)       mem_addr = rd_addr;
    else if (mem_write) mem_addr = wr_addr;
    mem_wdata          = mem_write ? zout_data : 32'd0;
    mem_byteenable     = mem_write ? {be_data[1], be_data[1], be_data[0], be_data[0]} : 4'd0;
    write_zfifo        = rd_ret;
    zfifo_wdata        = rd_ret ? mem_readdata : 32'd0;
    read_zbuffout_fifo = wr_acc;
    read_be_fifo       = wr_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base        <= '0;
      len_q       <= '0;
      issued      <= '0;
      received    <= '0;
      written     <= '0;
      outstanding <= '0;
      rd_hold     <= 1'b0;
    end else begin
      rd_hold <= mem_read && mem_waitrequest && !timeout_hit;
      if (state == IDLE) begin
        base        <= addr & 32'hFFFF_FFFC;
        len_q       <= len;
        issued      <= '0;
        received    <= '0;
        written     <= '0;
        outstanding <= '0;
      end else begin
        issued   <= issued + LEN_W'(rd_acc);
        received <= received + LEN_W'(rd_ret);
        written  <= written + LEN_W'(wr_acc);
        if (timeout_hit)
          outstanding <= '0;
        else if (rd_acc && !rd_ret)
          outstanding <= outstanding + OUT_W'(1);
        else if (!rd_acc && rd_ret)
          outstanding <= outstanding - OUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_zbuff_mem_port.sv
// Scoreboard bench for zbuff_mem_port: stimulus pushes expected bus beats, FIFO pushes and done cycles; a negedge monitor pops and compares.
module tb_zbuff_mem_port;
  localparam int LEN_W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1, rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, axi_done, write_zfifo, read_zbuffout_fifo, read_be_fifo;
  logic [31:0]      zfifo_wdata, mem_addr, mem_wdata;
  logic             mem_read, mem_write;
  logic [3:0]       mem_byteenable;
  logic             zfifo_afull = 1'b0;
  logic [31:0]      zout_data = '0;
  logic             zout_empty = 1'b1;
  logic [1:0]       be_data = '0;
  logic             be_empty = 1'b1;
  logic             mem_waitrequest = 1'b0;
  logic [31:0]      mem_readdata = '0;
  logic             mem_readdatavalid = 1'b0;
`ifdef ZBUFF_MEM_TIMEOUT_EN
  logic             err_timeout;
  bit               exp_err[$];
`endif

  zbuff_mem_port #(
    .MAX_OUT(4), .LEN_W(LEN_W)
`ifdef ZBUFF_MEM_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .len(len),
    .busy(busy), .axi_done(axi_done),
`ifdef ZBUFF_MEM_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .zfifo_wdata(zfifo_wdata), .write_zfifo(write_zfifo), .zfifo_afull(zfifo_afull),
    .zout_data(zout_data), .zout_empty(zout_empty), .read_zbuffout_fifo(read_zbuffout_fifo),
    .be_data(be_data), .be_empty(be_empty), .read_be_fifo(read_be_fifo),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
  );

  typedef struct {int due; logic [31:0] d;} rsp_t;

  int          checks = 0, errors = 0, cyc = 0;
  int          acc_cnt = 0, wacc_cnt = 0, done_cnt = 0, last_prog = 0, outst = 0;
  logic [31:0] exp_rd[$], exp_zd[$];
  logic [67:0] exp_wr[$];
  int          exp_done[$];
  logic [31:0] zq[$];
  logic [1:0]  bq[$];
  rsp_t        rq[$];
  logic        hold_empty = 1'b0, mem_stall = 1'b0;

  function automatic logic [31:0] pat(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(string nm, logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected event, value=%0h expected none (cycle %0d)", nm, act, cyc);
  endtask

  task automatic push_done(int c, bit err);
    exp_done.push_back(c);
`ifdef ZBUFF_MEM_TIMEOUT_EN
    exp_err.push_back(err);
`else
    if (err) $display("note: err flag ignored in this build");
`endif
  endtask

  task automatic do_req(bit r, bit w, logic [31:0] a, int l, output int rc);
    @(posedge clk); #1;
    rd_req = r; wr_req = w; addr = a; len = LEN_W'(l); rc = cyc;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic wait_done(int n0, int budget);
    int k = 0;
    while (done_cnt == n0 && k < budget) begin @(posedge clk); k++; end
    if (done_cnt == n0) begin
      checks++; errors++;
      $display("FAIL done_wait actual=no axi_done required=axi_done within %0d cycles", budget);
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("queues_drained", exp_rd.size() + exp_zd.size() + exp_wr.size() + exp_done.size(), 0);
  endtask

  task automatic wait_acc(int target);
    int k = 0;
    while (acc_cnt < target && k < 50) begin @(posedge clk); k++; end
    chk("accept_wait", acc_cnt >= target, 1);
  endtask

  function automatic logic [106:0] all_outs();
    return {busy, axi_done, write_zfifo, zfifo_wdata, read_zbuffout_fifo, read_be_fifo,
            mem_addr, mem_read, mem_write, mem_wdata, mem_byteenable};
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  // Memory model: read data returns two cycles after acceptance unless stalled.
  initial forever begin
    @(posedge clk); #1;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    if (!mem_stall && rq.size() > 0 && rq[0].due <= cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = rq[0].d;
      void'(rq.pop_front());
      outst--;
    end
  end

  // Show-ahead zbuffout / be FIFO model.
  initial forever begin
    logic pz, pb;
    @(negedge clk);
    pz = read_zbuffout_fifo && !reset;
    pb = read_be_fifo && !reset;
    @(posedge clk); #2;
    if (pz && zq.size() > 0) void'(zq.pop_front());
    if (pb && bq.size() > 0) void'(bq.pop_front());
    zout_data  = (zq.size() > 0) ? zq[0] : 32'd0;
    zout_empty = (zq.size() == 0) || hold_empty;
    be_data    = (bq.size() > 0) ? bq[0] : 2'd0;
    be_empty   = (bq.size() == 0) || hold_empty;
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (axi_done) begin
        done_cnt++;
        if (exp_done.size() == 0) unexp("axi_done", cyc);
        else begin
          int e;
          e = exp_done.pop_front();
          chk("done_cycle", cyc, (e < 0) ? last_prog + 1 : e);
`ifdef ZBUFF_MEM_TIMEOUT_EN
          chk("err_timeout", err_timeout, exp_err.pop_front());
`endif
        end
      end
      if (mem_read && !mem_waitrequest) begin
        if (exp_rd.size() == 0) unexp("rd_accept", mem_addr);
        else chk("rd_addr", mem_addr, exp_rd.pop_front());
        chk("outstanding_limit", outst < 4, 1);
        rq.push_back('{cyc + 2, pat(mem_addr)});
        outst++; acc_cnt++; last_prog = cyc;
      end
      if (write_zfifo) begin
        if (exp_zd.size() == 0) unexp("write_zfifo", zfifo_wdata);
        else chk("zfifo_wdata", zfifo_wdata, exp_zd.pop_front());
        last_prog = cyc;
      end
      chk("fifo_pops", {read_zbuffout_fifo, read_be_fifo}, {2{mem_write && !mem_waitrequest}});
      if (mem_write && !mem_waitrequest) begin
        if (exp_wr.size() == 0) unexp("wr_beat", {mem_addr, mem_wdata, mem_byteenable});
        else chk("wr_beat", {mem_addr, mem_wdata, mem_byteenable}, exp_wr.pop_front());
        wacc_cnt++; last_prog = cyc;
      end
      if (zfifo_afull) chk("read_while_afull", mem_read, 0);
      if (hold_empty)  chk("write_while_empty", mem_write, 0);
    end
  end

  initial begin
    int rc, a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 0);

    // Basic read burst, unaligned address, fixed timeline.
    exp_rd = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
    exp_zd = '{32'hD0DE_0000, 32'hD0DE_0004, 32'hD0DE_0008};
    do_req(1, 0, 32'h1000_0003, 3, rc);
    push_done(rc + 6, 0);
    wait_done(done_cnt, 30);

    // Throttle via zfifo_afull after two accepts.
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back(32'h4000 + 4 * i);
      exp_zd.push_back(pat(32'h4000 + 4 * i));
    end
    a0 = acc_cnt;
    do_req(1, 0, 32'h4000, 8, rc);
    push_done(-1, 0);
    wait_acc(a0 + 2);
    #1 zfifo_afull = 1'b1;
    repeat (6) @(posedge clk);
    #1 zfifo_afull = 1'b0;
    wait_done(done_cnt, 60);
    chk("throttle_accepts", acc_cnt - a0, 8);

    // Write burst with waitrequest on beat 0.
    zq = '{32'hAAAA_5555, 32'h1234_FFFF};
    bq = '{2'b01, 2'b11};
    exp_wr = '{{32'h0000_0100, 32'hAAAA_5555, 4'b0011}, {32'h0000_0104, 32'h1234_FFFF, 4'b1111}};
    a0 = wacc_cnt;
    mem_waitrequest = 1'b1;
    do_req(0, 1, 32'h0000_0100, 2, rc);
    push_done(rc + 6, 0);
    repeat (3) @(posedge clk);
    #1 mem_waitrequest = 1'b0;
    wait_done(done_cnt, 30);
    chk("write_fifos_empty", zq.size() + bq.size(), 0);

    // Simultaneous rd_req and wr_req: read only.
    zq = '{32'hDEAD_BEEF};
    bq = '{2'b11};
    exp_rd.push_back(32'h200);
    exp_zd.push_back(pat(32'h200));
    do_req(1, 1, 32'h200, 1, rc);
    push_done(-1, 0);
    wait_done(done_cnt, 30);
    chk("no_write_on_collision", zq.size(), 1);
    zq.delete(); bq.delete();

    // len == 0 for both directions.
    do_req(1, 0, 32'h300, 0, rc);
    push_done(rc + 1, 0);
    wait_done(done_cnt, 10);
    do_req(0, 1, 32'h300, 0, rc);
    push_done(rc + 1, 0);
    wait_done(done_cnt, 10);

    // FIFOs empty for 5 cycles mid-burst.
    zq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    bq = '{2'b10, 2'b00, 2'b11};
    exp_wr = '{{32'h400, 32'h1111_1111, 4'b1100}, {32'h404, 32'h2222_2222, 4'b0000},
               {32'h408, 32'h3333_3333, 4'b1111}};
    a0 = wacc_cnt;
    do_req(0, 1, 32'h400, 3, rc);
    push_done(-1, 0);
    begin
      int k = 0;
      while (wacc_cnt < a0 + 1 && k < 20) begin @(posedge clk); k++; end
    end
    #1 hold_empty = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold_empty = 1'b0;
    wait_done(done_cnt, 30);

    // Address wraparound.
    exp_rd = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_zd = '{pat(32'hFFFF_FFFC), pat(32'h0000_0000)};
    do_req(1, 0, 32'hFFFF_FFFC, 2, rc);
    push_done(-1, 0);
    wait_done(done_cnt, 30);

    // Reset with two reads outstanding; late returns must be ignored.
    mem_stall = 1'b1;
    exp_rd = '{32'h5000, 32'h5004};
    a0 = acc_cnt;
    do_req(1, 0, 32'h5000, 8, rc);
    wait_acc(a0 + 2);
    #1 zfifo_afull = 1'b1; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; zfifo_afull = 1'b0;
    @(negedge clk);
    chk("outputs_after_reset", all_outs(), 0);
    chk("reset_outstanding_model", outst, 2);
    mem_stall = 1'b0;
    begin
      int k = 0;
      while (rq.size() > 0 && k < 20) begin @(posedge clk); k++; end
    end
    repeat (2) @(posedge clk);
    chk("late_returns_drained", rq.size(), 0);
    exp_rd.push_back(32'h6000);
    exp_zd.push_back(pat(32'h6000));
    do_req(1, 0, 32'h6000, 1, rc);
    push_done(rc + 4, 0);
    wait_done(done_cnt, 30);

`ifdef ZBUFF_MEM_TIMEOUT_EN
    mem_waitrequest = 1'b1;
    do_req(1, 0, 32'h7000, 2, rc);
    push_done(rc + 16, 1);
    wait_done(done_cnt, 40);
    mem_waitrequest = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end
endmodule
